// File: rtl/hms_timer_pkg.sv
// ============================================================================
//  Module  : hms_timer_pkg
//  Purpose : Shared field limits, widths and count-direction encodings.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hms_timer_pkg;

    localparam int FIELD_W = 6;

    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    // Validity of a loaded minute/second field.
    function automatic logic field_ok(input logic [FIELD_W-1:0] value,
                                      input logic [FIELD_W-1:0] max_value);
        return (value <= max_value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module  : tick_prescaler
//  Purpose : Divides enabled clk cycles by CLK_DIV and flags the advance cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   c_last = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcnt <= '0;
        end else if (clr) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= (r_pcnt == c_last) ? '0 : r_pcnt + 1'b1;
        end
    end

    assign tick = en && !clr && (r_pcnt == c_last);

endmodule

`default_nettype wire

// File: rtl/hms_timer.sv
// ============================================================================
//  Module  : hms_timer
//  Purpose : Up/down hours:minutes:seconds timer with load, alarm and flags.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hms_timer
    import hms_timer_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int HOUR_W   = 5,
    parameter int HOUR_MAX = 23
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_sec,
    input  logic [FIELD_W-1:0] load_min,
    input  logic [HOUR_W-1:0]  load_hr,
    input  logic               alarm_en,
    input  logic [FIELD_W-1:0] alarm_sec,
    input  logic [FIELD_W-1:0] alarm_min,
    input  logic [HOUR_W-1:0]  alarm_hr,
    input  logic               clr_flags,
    output logic [FIELD_W-1:0] sec,
    output logic [FIELD_W-1:0] min,
    output logic [HOUR_W-1:0]  hr,
    output logic               sec_tick,
    output logic               ovf,
    output logic               done,
    output logic               alarm,
    output logic               load_err,
    output logic               zero
);

    localparam logic [HOUR_W-1:0] c_hr_max = HOUR_W'(HOUR_MAX);

    logic [FIELD_W-1:0] r_sec, r_min;
    logic [HOUR_W-1:0]  r_hr;
    logic               r_sec_tick, r_ovf, r_done, r_alarm, r_load_err;

    logic               w_load_ok, w_tick, w_zero, w_step;
    logic [FIELD_W-1:0] w_nsec, w_nmin;
    logic [HOUR_W-1:0]  w_nhr;
    logic               w_wrap, w_reach0, w_match;

    assign w_load_ok = field_ok(load_sec, SEC_MAX) && field_ok(load_min, MIN_MAX)
                    && (load_hr <= c_hr_max);

    // Any load (good or bad) freezes the prescaler; only a good load clears it.
    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en && !load),
        .clr   (load && w_load_ok),
        .tick  (w_tick)
    );

    assign w_zero = (r_sec == '0) && (r_min == '0) && (r_hr == '0);
    assign w_step = w_tick && !((dir == DOWN) && w_zero);

    always_comb begin
        w_nsec   = r_sec;
        w_nmin   = r_min;
        w_nhr    = r_hr;
        w_wrap   = 1'b0;
        w_reach0 = 1'b0;
        if (dir == UP) begin
            if (r_sec == SEC_MAX) begin
                w_nsec = '0;
                if (r_min == MIN_MAX) begin
                    w_nmin = '0;
                    if (r_hr == c_hr_max) begin
                        w_nhr  = '0;
                        w_wrap = 1'b1;
                    end else begin
                        w_nhr = r_hr + 1'b1;
                    end
                end else begin
                    w_nmin = r_min + 1'b1;
                end
            end else begin
                w_nsec = r_sec + 1'b1;
            end
        end else begin
            if (r_sec == '0) begin
                w_nsec = SEC_MAX;
                if (r_min == '0) begin
                    w_nmin = MIN_MAX;
                    w_nhr  = (r_hr == '0) ? c_hr_max : r_hr - 1'b1;
                end else begin
                    w_nmin = r_min - 1'b1;
                end
            end else begin
                w_nsec = r_sec - 1'b1;
            end
            w_reach0 = (r_hr == '0) && (r_min == '0) && (r_sec == 6'd1);
        end
    end

    assign w_match = (w_nsec == alarm_sec) && (w_nmin == alarm_min) && (w_nhr == alarm_hr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec      <= '0;
            r_min      <= '0;
            r_hr       <= '0;
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_load_err <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_alarm    <= 1'b0;
            r_load_err <= load && !w_load_ok;
            if (load) begin
                if (w_load_ok) begin
                    r_sec <= load_sec;
                    r_min <= load_min;
                    r_hr  <= load_hr;
                end
            end else if (w_step) begin
                r_sec      <= w_nsec;
                r_min      <= w_nmin;
                r_hr       <= w_nhr;
                r_sec_tick <= 1'b1;
                r_alarm    <= alarm_en && w_match;
            end
            // Set beats a simultaneous clear.
            r_ovf  <= (w_step && w_wrap)   || (r_ovf  && !clr_flags);
            r_done <= (w_step && w_reach0) || (r_done && !clr_flags);
        end
    end

    assign sec      = r_sec;
    assign min      = r_min;
    assign hr       = r_hr;
    assign sec_tick = r_sec_tick;
    assign ovf      = r_ovf;
    assign done     = r_done;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;
    assign zero     = w_zero;

endmodule

`default_nettype wire

// File: tb/tb_hms_timer.sv
// ============================================================================
//  Module  : tb_hms_timer
//  Purpose : Scoreboard bench for hms_timer (CLK_DIV=4, HOUR_MAX=23).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hms_timer;

    localparam int CLK_DIV  = 4;
    localparam int HOUR_W   = 5;
    localparam int HOUR_MAX = 23;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0, dir = 1'b0, load = 1'b0, clr_flags = 1'b0;
    logic [5:0]        load_sec = '0, load_min = '0;
    logic [HOUR_W-1:0] load_hr = '0;
    logic              alarm_en = 1'b0;
    logic [5:0]        alarm_sec = '0, alarm_min = '0;
    logic [HOUR_W-1:0] alarm_hr = '0;
    logic [5:0]        sec, min;
    logic [HOUR_W-1:0] hr;
    logic              sec_tick, ovf, done, alarm, load_err, zero;

    hms_timer #(
        .CLK_DIV  (CLK_DIV),
        .HOUR_W   (HOUR_W),
        .HOUR_MAX (HOUR_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .dir       (dir),
        .load      (load),
        .load_sec  (load_sec),
        .load_min  (load_min),
        .load_hr   (load_hr),
        .alarm_en  (alarm_en),
        .alarm_sec (alarm_sec),
        .alarm_min (alarm_min),
        .alarm_hr  (alarm_hr),
        .clr_flags (clr_flags),
        .sec       (sec),
        .min       (min),
        .hr        (hr),
        .sec_tick  (sec_tick),
        .ovf       (ovf),
        .done      (done),
        .alarm     (alarm),
        .load_err  (load_err),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]        s;
        logic [5:0]        m;
        logic [HOUR_W-1:0] h;
        logic              ovf;
        logic              done;
        logic              alm;
    } exp_t;

    exp_t exp_q[$];

    int total = 0, bad = 0;
    int cyc = 0, tick_cnt = 0, le_cnt = 0, al_cnt = 0;
    int last_tick = 0;
    bit have_last = 0, period_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int s, input int m, input int h,
                        input bit o, input bit d, input bit a);
        exp_t e;
        e.s = 6'(s); e.m = 6'(m); e.h = HOUR_W'(h);
        e.ovf = o; e.done = d; e.alm = a;
        exp_q.push_back(e);
    endtask

    // Pops one expected entry per sec_tick the DUT presents.
    task automatic monitor();
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (load_err) le_cnt++;
                if (alarm)    al_cnt++;
                if (sec_tick) begin
                    tick_cnt++;
                    got = {sec, min, hr, ovf, done, alarm};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_tick: got %0h want none (t=%0t)", got, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL tick_state: got %0h want %0h (t=%0t)", got, e, $time);
                        end
                    end
                    if (period_chk && have_last) begin
                        chk("tick_period", 32'(cyc - last_tick), 32'(CLK_DIV));
                    end
                    last_tick = cyc;
                    have_last = 1;
                end
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int s, input int m, input int h);
        load = 1'b1;
        load_sec = 6'(s); load_min = 6'(m); load_hr = HOUR_W'(h);
        step(1);
        load = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
    endtask

    int saved;

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        #1;
        chk("reset_time", {26'd0, sec, min, hr} , 32'd0);
        chk("reset_flags", {26'd0, sec_tick, ovf, done, alarm, load_err, 1'b0}, 32'd0);
        chk("reset_zero", {31'd0, zero}, 32'd1);

        // Free-run up for 240 cycles
        step(2);
        reset = 1'b1; en = 1'b1; dir = 1'b0; period_chk = 1;
        for (int t = 1; t <= 60; t++) push(t % 60, t / 60, 0, 0, 0, 0);
        step(3);
        chk("first_adv_early", {26'd0, sec}, 32'd0);
        step(1);
        chk("first_adv", {26'd0, sec}, 32'd1);
        step(236);
        period_chk = 0; en = 1'b0;
        chk("run_time", {15'd0, sec, min, hr}, {15'd0, 6'd0, 6'd1, 5'd0});
        chk("run_ovf", {31'd0, ovf}, 32'd0);

        // Wrap with clear on the same edge, then a later clear
        clear_flags();
        en = 1'b1;
        push(59, 59, 23, 0, 0, 0);
        push(0, 0, 0, 1, 0, 0);
        do_load(58, 59, 23);
        step(7);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        chk("wrap_ovf_set_wins", {31'd0, ovf}, 32'd1);
        step(1);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        push(1, 0, 0, 0, 0, 0);
        step(2);
        en = 1'b0;
        chk("count_after_clr", {26'd0, sec}, 32'd1);

        // Count down to zero and hold there
        clear_flags();
        en = 1'b1; dir = 1'b1;
        push(1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 1, 0);
        do_load(2, 0, 0);
        step(8);
        chk("down_zero", {31'd0, zero}, 32'd1);
        chk("down_done", {31'd0, done}, 32'd1);
        step(1);
        saved = tick_cnt;
        step(11);
        chk("hold_no_tick", 32'(tick_cnt), 32'(saved));
        chk("hold_time", {15'd0, sec, min, hr}, 32'd0);
        chk("hold_done", {31'd0, done}, 32'd1);

        // Out-of-range load keeps time and prescaler
        en = 1'b0;
        clear_flags();
        dir = 1'b0; en = 1'b1;
        do_load(10, 0, 0);
        step(2);
        saved = le_cnt;
        do_load(60, 0, 0);
        chk("bad_load_err", {31'd0, load_err}, 32'd1);
        chk("bad_load_time", {26'd0, sec}, 32'd10);
        push(11, 0, 0, 0, 0, 0);
        step(1);
        chk("bad_load_err_pulse", {31'd0, load_err}, 32'd0);
        chk("bad_load_pcnt_kept", {26'd0, sec}, 32'd10);
        step(1);
        chk("bad_load_adv", {26'd0, sec}, 32'd11);
        en = 1'b0;
        step(1);
        chk("load_err_count", 32'(le_cnt - saved), 32'd1);

        // Alarm on counting into 00:01:00, never on load
        clear_flags();
        alarm_en = 1'b1; alarm_sec = 6'd0; alarm_min = 6'd1; alarm_hr = '0;
        saved = al_cnt;
        en = 1'b1;
        push(59, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 1);
        push(1, 1, 0, 0, 0, 0);
        do_load(58, 0, 0);
        step(12);
        en = 1'b0;
        step(2);
        chk("alarm_count", 32'(al_cnt - saved), 32'd1);
        do_load(0, 1, 0);
        step(3);
        chk("alarm_not_on_load", 32'(al_cnt - saved), 32'd1);

        // Asynchronous reset mid-count
        en = 1'b1;
        do_load(5, 3, 2);
        step(2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_time", {15'd0, sec, min, hr}, 32'd0);
        chk("async_rst_flags", {27'd0, sec_tick, ovf, done, alarm, load_err}, 32'd0);
        en = 1'b0;
        step(1);
        reset = 1'b1;
        step(2);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
